// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: multi-digit BCD down-counter with IDLE/RUN/PAUSE/DONE control and prescaler.
module bcd_countdown_timer #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                start,
    input  logic                stop,
    output logic [4*DIGITS-1:0] cnt,
    output logic                running,
    output logic                done
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state;
    logic [PW-1:0] pre;
    logic [W-1:0]  san_val;
    logic [W-1:0]  dec_val;

    function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++)
            r[4*i+:4] = v[4*i+:4] > 4'd9 ? 4'd9 : v[4*i+:4];
        return r;
    endfunction

    // borrow ripples from digit 0 upward; a zero digit wraps to 9
    function automatic logic [W-1:0] decrement(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i+:4] = b ? (v[4*i+:4] == 4'd0 ? 4'd9 : v[4*i+:4] - 4'd1) : v[4*i+:4];
            b = b && (v[4*i+:4] == 4'd0);
        end
        return r;
    endfunction

    always_comb begin
        san_val = sanitize(load_val);
        dec_val = decrement(cnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            state   <= IDLE;
            pre     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                cnt     <= san_val;
                state   <= IDLE;
                pre     <= '0;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (!stop && start && cnt != '0) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    RUN: if (stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (cnt == '0) begin
                        state   <= DONE;
                        running <= 1'b0;
                    end else if (pre == PW'(PRESCALE - 1)) begin
                        pre <= '0;
                        cnt <= dec_val;
                        if (dec_val == '0) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        pre <= pre + PW'(1);
                    end
                    PAUSE: if (!stop && start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    DONE: state <= DONE;
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
